// File: rtl/hex_digit_sum_arbiter.sv
// hex_digit_sum_arbiter
//   Round-robin arbiter in front of a single nibble-serial digit-sum engine.
//   A winner's operand is captured into a shift register and one hex digit
//   is added per clock. The total is returned on sum/done_id with a one-cycle
//   done pulse.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   req      per-requester level request, held until its gnt bit is seen
//   num_bus  packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt      one-hot, one-cycle pulse on the capture edge
//   busy     high while the engine is not idle
//   done     one-cycle pulse, sum/done_id valid
//   done_id  owner of the result on sum (held until the next done)
//   sum      hex-digit sum of the captured operand (held until the next done)
//
// Reset release is taken directly: the first arbitration happens at the
// first rising edge after rst goes high, so rst must be released away from
// the rising edge by the driving logic.
module hex_digit_sum_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int WIDTH = 32,
    parameter int SUM_W = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] num_bus,
    output logic [N_REQ-1:0]       gnt,
    output logic                   busy,
    output logic                   done,
    output logic [ID_W-1:0]        done_id,
    output logic [SUM_W-1:0]       sum
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   owner;
    logic [WIDTH-1:0]  shreg;
    logic [SUM_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;

    logic [ID_W-1:0]   win;
    logic [ID_W-1:0]   cand;
    logic              found;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [WIDTH-1:0]  operand;
    logic [SUM_W-1:0]  digit;
    logic              last_digit;

    // Round-robin scan starting just after the last winner; the first set
    // request bit in that rotated order wins.
    always_comb begin
        win   = ptr;
        cand  = ptr;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = ID_W'((int'(ptr) + i) % N_REQ);
            if (!found && req[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        gnt_nxt      = '0;
        gnt_nxt[win] = 1'b1;
    end

    assign operand    = num_bus[int'(win)*WIDTH +: WIDTH];
    assign digit      = SUM_W'(shreg[3:0]);
    assign last_digit = (state == RUN) && (cnt == CNT_W'(DIGITS - 1));

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|req) state_nxt = RUN;
            RUN:     if (last_digit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic (busy is the only purely combinational output)
    always_comb begin
        busy = (state != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= ID_W'(N_REQ - 1);
            owner   <= '0;
            shreg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            sum     <= '0;
        end else begin
            gnt  <= '0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        shreg <= operand;
                        acc   <= '0;
                        cnt   <= '0;
                        owner <= win;
                        ptr   <= win;
                        gnt   <= gnt_nxt;
                    end
                end
                RUN: begin
                    acc   <= acc + digit;
                    shreg <= shreg >> 4;
                    cnt   <= cnt + CNT_W'(1);
                    // Publish the total including the digit added on this edge.
                    if (last_digit) begin
                        sum     <= acc + digit;
                        done_id <= owner;
                        done    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hex_digit_sum_arbiter.sv
// Testbench for hex_digit_sum_arbiter: a timeline model predicts every output
// each cycle, and directed scenarios pin the model with hand-computed values.
module tb_hex_digit_sum_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;
    localparam int WIDTH = 32;
    localparam int SUM_W = 7;
    localparam int DIG   = WIDTH / 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] num_bus = '0;
    logic [N_REQ-1:0]       gnt;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [SUM_W-1:0]       sum;

    logic [N_REQ-1:0]       keep = '0;

    int checks = 0;
    int errors = 0;

    // Observation logs (written only by the compare process)
    int g_id[$], g_cyc[$], d_id[$], d_sum[$], d_cyc[$];

    hex_digit_sum_arbiter #(
        .N_REQ(N_REQ), .ID_W(ID_W), .WIDTH(WIDTH), .SUM_W(SUM_W)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .num_bus(num_bus),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .sum(sum)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int digsum(input logic [WIDTH-1:0] v);
        int s = 0;
        for (int k = 0; k < DIG; k++) s += int'(v[k*4 +: 4]);
        return s;
    endfunction

    function automatic int at(input int q[$], input int k);
        return (k < q.size()) ? q[k] : -1;
    endfunction

    // Model: one transaction occupies E0 (grant) .. E0+DIG (done),
    // and the engine is free again at E0+DIG+2.
    int cyc = 0;
    bit have = 0;
    int t0 = 0, w = 0, next_arb = 0, last = N_REQ - 1;
    int exp_sum = 0, res_sum = 0, res_id = 0;

    initial begin
        logic [N_REQ-1:0] e_gnt;
        bit e_busy, e_done;
        int c;
        bit fnd;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst) begin
                have = 0; next_arb = 0; last = N_REQ - 1; res_sum = 0; res_id = 0;
            end else if (cyc >= next_arb && req != '0) begin
                fnd = 0;
                for (int k = 1; k <= N_REQ; k++) begin
                    c = (last + k) % N_REQ;
                    if (!fnd && req[c]) begin fnd = 1; w = c; end
                end
                last = w; have = 1; t0 = cyc; next_arb = cyc + DIG + 2;
                exp_sum = digsum(num_bus[w*WIDTH +: WIDTH]);
            end
            #1;
            e_gnt  = (have && cyc == t0) ? (N_REQ'(1) << w) : '0;
            e_busy = have && cyc >= t0 && cyc <= t0 + DIG;
            e_done = have && cyc == t0 + DIG;
            if (e_done) begin res_sum = exp_sum; res_id = w; end
            chk("gnt", gnt, e_gnt);
            chk("busy", busy, e_busy);
            chk("done", done, e_done);
            chk("done_id", done_id, res_id);
            chk("sum", sum, res_sum);
            for (int k = 0; k < N_REQ; k++)
                if (gnt[k]) begin g_id.push_back(k); g_cyc.push_back(cyc); end
            if (done) begin
                d_id.push_back(int'(done_id)); d_sum.push_back(int'(sum)); d_cyc.push_back(cyc);
            end
        end
    end

    // Each requester drops its bit when it sees its grant; bits in keep are
    // re-raised on the following cycle.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req = (req & ~gnt) | (keep & ~gnt);
        end
    endtask

    task automatic setop(input int i, input logic [WIDTH-1:0] v);
        num_bus[i*WIDTH +: WIDTH] = v;
    endtask

    initial begin
        int mg, md;
        // Reset state
        step(2);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_done_id", done_id, 0);
        rst = 1'b1;
        step(2);

        // Single request
        mg = g_id.size(); md = d_id.size();
        setop(0, 32'h0000A1FB);
        req = 4'b0001;
        step(13);
        chk("single_ngnt", g_id.size() - mg, 1);
        chk("single_gid", at(g_id, mg), 0);
        chk("single_sum", at(d_sum, md), 37);
        chk("single_did", at(d_id, md), 0);
        chk("single_lat", at(d_cyc, md) - at(g_cyc, mg), 8);

        // Extreme operands
        md = d_id.size();
        setop(2, 32'hFFFFFFFF);
        req = 4'b0100;
        step(12);
        chk("ff_sum", at(d_sum, md), 120);
        chk("ff_did", at(d_id, md), 2);
        step(5);
        chk("ff_hold", sum, 120);
        md = d_id.size();
        setop(1, 32'h00000000);
        req = 4'b0010;
        step(12);
        chk("zero_sum", at(d_sum, md), 0);
        chk("zero_did", at(d_id, md), 1);

        // Contention from reset
        rst = 1'b0;
        step(2);
        setop(3, 32'h00000005);
        mg = g_id.size(); md = d_id.size();
        req = 4'b1111;
        rst = 1'b1;
        step(45);
        chk("cont_ngnt", g_id.size() - mg, 4);
        for (int k = 0; k < 4; k++) begin
            chk("cont_gid", at(g_id, mg + k), k);
            chk("cont_did", at(d_id, md + k), k);
        end
        for (int k = 1; k < 4; k++)
            chk("cont_space", at(g_cyc, mg + k) - at(g_cyc, mg + k - 1), 10);

        // Fairness after a grant to 3
        mg = g_id.size();
        keep = 4'b0101;
        req  = 4'b0101;
        step(60);
        chk("fair_g0", at(g_id, mg), 0);
        chk("fair_g1", at(g_id, mg + 1), 2);
        chk("fair_g2", at(g_id, mg + 2), 0);
        chk("fair_g3", at(g_id, mg + 3), 2);
        for (int k = mg + 1; k < g_id.size(); k++)
            chk("fair_alt", (g_id[k] == 0 && g_id[k-1] == 0) ? 1 : 0, 0);
        keep = '0;
        req  = '0;
        step(12);

        // Reset mid-RUN
        mg = g_id.size();
        setop(1, 32'h00000003);
        req = 4'b0010;
        step(4);
        chk("mid_gnt_seen", g_id.size() - mg, 1);
        rst = 1'b0;
        #1;
        chk("mid_gnt", gnt, 0);
        chk("mid_busy", busy, 0);
        chk("mid_done", done, 0);
        chk("mid_sum", sum, 0);
        chk("mid_did", done_id, 0);
        md = d_id.size();
        step(3);
        chk("mid_nodone", d_id.size() - md, 0);
        mg = g_id.size();
        setop(3, 32'h12345678);
        req = 4'b1000;
        rst = 1'b1;
        step(12);
        chk("post_sum", at(d_sum, md), 36);
        chk("post_did", at(d_id, md), 3);
        chk("post_lat", at(d_cyc, md) - at(g_cyc, mg), 8);

        // Late request while busy
        mg = g_id.size(); md = d_id.size();
        setop(0, 32'h11111111);
        req = 4'b0001;
        step(4);
        setop(1, 32'h0000000F);
        req = req | 4'b0010;
        step(22);
        chk("late_g0", at(g_id, mg), 0);
        chk("late_g1", at(g_id, mg + 1), 1);
        chk("late_gap", at(g_cyc, mg + 1) - at(g_cyc, mg), 10);
        chk("late_after_done", at(g_cyc, mg + 1) - at(d_cyc, md), 2);
        chk("late_sum0", at(d_sum, md), 8);
        chk("late_sum1", at(d_sum, md + 1), 15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
